// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - instruction fetch stage with fetch/decode pipeline register
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_en_o,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] fd_pc_o,
   output logic [31:0] fd_pc_plus4_o,
   output logic [31:0] fd_instr_o,
   output logic        fd_valid_o,
   output logic        fd_misalign_o
);

   // pc_q is the PC whose instruction is on imem_rdata_i this cycle
   logic [31:0] pc_q;
   logic        rd_valid_q;
   logic [31:0] next_pc;
   logic [31:0] fd_pc_q;
   logic [31:0] fd_instr_q;
   logic        fd_valid_q;
   logic        fd_misalign_q;

   // Next fetch address: redirect first, then the boot refetch, then stall hold, else sequential
   always_comb begin
      next_pc = pc_q + 32'd4;
      if (flush_i) begin
         next_pc = redirect_pc_i;
      end else if (!rd_valid_q) begin
         next_pc = pc_q;
      end else if (stall_i) begin
         next_pc = pc_q;
      end
   end

   // Memory is word addressed; an unaligned PC still fetches its containing word
   assign imem_addr_o = {next_pc[31:2], 2'b00};
   // Memory must keep its output only while a real stall holds the stage
   assign imem_en_o   = flush_i | !rd_valid_q | !stall_i;

   // PC register; the memory output becomes meaningful after the first edge
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pc_q       <= RESET_PC;
         rd_valid_q <= 1'b0;
      end else begin
         pc_q       <= next_pc;
         rd_valid_q <= 1'b1;
      end
   end

   // Fetch/decode register: flush beats stall, stall freezes, then bubble / fault / real instruction
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fd_pc_q       <= RESET_PC;
         fd_instr_q    <= NOP_INSTR;
         fd_valid_q    <= 1'b0;
         fd_misalign_q <= 1'b0;
      end else if (flush_i) begin
         fd_instr_q    <= NOP_INSTR;
         fd_valid_q    <= 1'b0;
         fd_misalign_q <= 1'b0;
      end else if (stall_i) begin
         fd_pc_q       <= fd_pc_q;
      end else if (!rd_valid_q) begin
         fd_instr_q    <= NOP_INSTR;
         fd_valid_q    <= 1'b0;
         fd_misalign_q <= 1'b0;
      end else if (pc_q[1:0] != 2'b00) begin
         fd_pc_q       <= pc_q;
         fd_instr_q    <= NOP_INSTR;
         fd_valid_q    <= 1'b1;
         fd_misalign_q <= 1'b1;
      end else begin
         fd_pc_q       <= pc_q;
         fd_instr_q    <= imem_rdata_i;
         fd_valid_q    <= 1'b1;
         fd_misalign_q <= 1'b0;
      end
   end

   assign fd_pc_o       = fd_pc_q;
   assign fd_pc_plus4_o = fd_pc_q + 32'd4;
   assign fd_instr_o    = fd_instr_q;
   assign fd_valid_o    = fd_valid_q;
   assign fd_misalign_o = fd_misalign_q;

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch stage plus the fetch/decode pipeline register; sits directly upstream of the decode/execute register.
- Owns the program counter and drives the synchronous instruction memory.
- Registers {pc, instruction, valid, misalign} for the decode stage.
- Applies stalls from the hazard unit and flushes/redirects from the execute stage. Branch penalty is one bubble.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on fd_instr_o when invalid.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous, active-low
- stall_i  input  1  hazard unit: hold PC and fetch/decode register
- flush_i  input  1  execute stage: branch taken or jump; kill fetch/decode contents and redirect
- redirect_pc_i  input  32  target PC, sampled when flush_i=1
- imem_addr_o  output  32  word-aligned address presented to instruction memory (combinational)
- imem_en_o  output  1  memory read enable; memory holds its output when 0
- imem_rdata_i  input  32  instruction for the address latched by memory on the previous edge
- fd_pc_o  output  32  PC of the registered instruction
- fd_pc_plus4_o  output  32  fd_pc_o + 4, modulo 2^32 (combinational)
- fd_instr_o  output  32  registered instruction
- fd_valid_o  output  1  registered instruction is real (not a bubble)
- fd_misalign_o  output  1  registered slot carries an instruction-address-misaligned fault

Behaviour:
- Reset is asynchronous and active-low. One clock, clk_i.
- Internal state:
  - pc_q: PC whose instruction appears on imem_rdata_i this cycle.
  - rd_valid_q: memory output is meaningful.
- Reset values:
  - pc_q=RESET_PC, rd_valid_q=0
  - fd_pc_o=RESET_PC, fd_instr_o=NOP_INSTR, fd_valid_o=0, fd_misalign_o=0
  - imem_addr_o=RESET_PC, imem_en_o=1
- next_pc priority:
  - flush_i → redirect_pc_i
  - else !rd_valid_q → pc_q (boot fetch)
  - else stall_i → pc_q
  - else pc_q+4 (wraps at 2^32)
- imem_addr_o = {next_pc[31:2],2'b00}.
- imem_en_o = flush_i | !rd_valid_q | !stall_i.
- Every edge: pc_q<=next_pc; rd_valid_q<=1.
- Fetch/decode register update, highest priority first:
  - flush_i: fd_valid<=0, fd_instr<=NOP_INSTR, fd_misalign<=0, fd_pc holds. Flush beats a simultaneous stall_i.
  - stall_i: all fd_* hold. pc_q holds, memory output holds.
  - !rd_valid_q: fd_valid<=0, fd_instr<=NOP_INSTR (boot bubble).
  - pc_q[1:0]!=0: fd_pc<=pc_q, fd_instr<=NOP_INSTR, fd_valid<=1, fd_misalign<=1.
  - otherwise: fd_pc<=pc_q, fd_instr<=imem_rdata_i, fd_valid<=1, fd_misalign<=0.
- Latency:
  - First valid instruction on fd_* appears at the 2nd rising edge after rst_n_i deasserts.
  - Redirect target appears on fd_* 2 edges after the flush edge, giving exactly one bubble.
- Misaligned redirect: pc_q keeps the unaligned value and increments by 4. Every following slot is misaligned until the next flush. The trap logic downstream issues that flush.
- stall_i held for N cycles: fd_* and pc_q are frozen for N edges; no instruction is lost or duplicated.
- stall_i and flush_i in the same cycle: treated as a flush.
- Reset asserted mid-operation: every register returns to its reset value immediately, without waiting for a clock edge.

Test Plan:
1. Release reset, imem returns mem[a]=a^32'hA5A5_0000 → edge 1: fd_valid=0. Edge 2: fd_pc=0, fd_instr=32'hA5A5_0000, fd_valid=1. Edge 3: fd_pc=4, fd_pc_plus4=8.
2. Stall at fd_pc=8 held 3 cycles → fd_pc=8, fd_instr unchanged, imem_en_o=0 all 3 cycles. Next edge fd_pc=C; no gap, no duplicate.
3. flush_i=1 with redirect_pc_i=0x100 while fd_pc=0x10 → next edge fd_valid=0, fd_instr=0x0000_0013. Following edge fd_pc=0x100, fd_valid=1.
4. flush_i and stall_i both 1, redirect 0x200 → flush wins. imem_addr_o=0x200 that cycle. Two edges later fd_pc=0x200.
5. Redirect to 0x102 → fd_pc=0x102, fd_misalign=1, fd_instr=NOP, fd_valid=1. Next slot fd_pc=0x106, fd_misalign=1. Redirect to 0x300 clears fd_misalign.
6. PC at 0xFFFF_FFFC, no stall → fd_pc_plus4=0 and next fd_pc=0. Assert rst_n_i low mid-stream → fd_valid=0 and fd_pc=RESET_PC asynchronously, before any clock edge.
